// File: rtl/obi_cmd_master_if.sv
// ============================================================================
// obi_req_if / obi_rsp_if : OBI request and response channel bundles
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface obi_req_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [3:0]            be;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic                  gnt;

  modport master (output req, we, be, addr, wdata, input gnt);
  modport slave  (input req, we, be, addr, wdata, output gnt);
endinterface

interface obi_rsp_if;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output rvalid, rdata);
  modport slave  (input rvalid, rdata);
endinterface

`default_nettype wire

// File: rtl/obi_cmd_master.sv
// ============================================================================
// obi_cmd_master : command stream to single-outstanding OBI transactions
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module obi_cmd_master #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [1:0]            cmd_size_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [31:0]           cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
  obi_req_if.master             bus_req,
  obi_rsp_if.slave              bus_rsp
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RSP  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_accept;
  logic                  w_legal;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata_rep;
  logic [31:0]           w_rd_shift;
  logic [31:0]           w_rd_ext;

  logic                  r_we;
  logic [1:0]            r_size;
  logic [1:0]            r_off;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_be;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_err;

  // Legality, byte enables and lane replication from the incoming command
  always_comb begin
    w_legal     = 1'b0;
    w_be        = 4'h0;
    w_wdata_rep = cmd_wdata_i;
    case (cmd_size_i)
      2'd0: begin
        w_legal     = 1'b1;
        w_be        = 4'b0001 << cmd_addr_i[1:0];
        w_wdata_rep = {4{cmd_wdata_i[7:0]}};
      end
      2'd1: begin
        w_legal     = ~cmd_addr_i[0];
        w_be        = 4'b0011 << cmd_addr_i[1:0];
        w_wdata_rep = {2{cmd_wdata_i[15:0]}};
      end
      2'd2: begin
        w_legal     = (cmd_addr_i[1:0] == 2'b00);
        w_be        = 4'hF;
      end
      default: ;
    endcase
  end

  assign w_rd_shift = bus_rsp.rdata >> {r_off, 3'b000};

  always_comb begin
    case (r_size)
      2'd0:    w_rd_ext = {24'b0, w_rd_shift[7:0]};
      2'd1:    w_rd_ext = {16'b0, w_rd_shift[15:0]};
      default: w_rd_ext = w_rd_shift;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = w_legal ? S_REQ : S_RSP;
        end
      end
      S_REQ:  if (bus_req.gnt)    w_state_nxt = S_WAIT;
      // rvalid is only honoured here, so a response in the grant cycle is never taken
      S_WAIT: if (bus_rsp.rvalid) w_state_nxt = S_RSP;
      S_RSP:  if (rsp_ready_i)    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we    <= 1'b0;
      r_size  <= 2'd0;
      r_off   <= 2'd0;
      r_addr  <= '0;
      r_be    <= 4'h0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_we    <= cmd_we_i;
      r_size  <= cmd_size_i;
      r_off   <= cmd_addr_i[1:0];
      r_addr  <= {cmd_addr_i[ADDR_WIDTH-1:2], 2'b00};
      r_be    <= w_be;
      r_wdata <= w_wdata_rep;
      r_rdata <= 32'h0;
      r_err   <= ~w_legal;
    end else if (r_state == S_WAIT && bus_rsp.rvalid && !r_we) begin
      r_rdata <= w_rd_ext;
    end
  end

  assign cmd_ready_o   = (r_state == S_IDLE);
  assign busy_o        = (r_state != S_IDLE);
  assign rsp_valid_o   = (r_state == S_RSP);
  assign rsp_rdata_o   = r_rdata;
  assign rsp_err_o     = r_err;
  assign bus_req.req   = (r_state == S_REQ);
  assign bus_req.we    = r_we;
  assign bus_req.be    = r_be;
  assign bus_req.addr  = r_addr;
  assign bus_req.wdata = r_wdata;

  a_rvalid_only_in_wait: assert property (
    @(posedge clk_i) disable iff (!rst_ni) bus_rsp.rvalid |-> (r_state == S_WAIT)
  );

endmodule

`default_nettype wire

// File: tb/tb_obi_cmd_master.sv
// ============================================================================
// tb_obi_cmd_master : directed and randomized checks of obi_cmd_master
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_obi_cmd_master;

  logic        clk_i;
  logic        rst_ni;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [1:0]  cmd_size_i;
  logic [31:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        busy_o;

  int checks;
  int errors;

  obi_req_if #(.ADDR_WIDTH(32)) req_if ();
  obi_rsp_if                    rsp_if ();

  obi_cmd_master #(.ADDR_WIDTH(32)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_we_i    (cmd_we_i),
    .cmd_size_i  (cmd_size_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_wdata_i (cmd_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .busy_o      (busy_o),
    .bus_req     (req_if),
    .bus_rsp     (rsp_if)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One command end to end; caller sits at a negedge with the DUT idle.
  // gd = cycles gnt held low, rd = idle WAIT cycles before rvalid, pd = cycles rsp_ready held low.
  task automatic run_cmd(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] srd,
                         input int gd, input int rd, input int pd);
    int          nb;
    int          off;
    logic        legal;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic [31:0] erd;
    logic [31:0] mask;
    logic [31:0] eaddr;
    nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off   = int'(addr[1:0]);
    legal = (size != 2'd3) && ((int'(addr[1:0]) % nb) == 0);
    ebe   = 4'(((1 << nb) - 1) << off);
    ewd   = (nb == 1) ? wd[7:0] * 32'h0101_0101 : (nb == 2) ? wd[15:0] * 32'h0001_0001 : wd;
    mask  = (nb == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * nb)) - 64'd1);
    erd   = (!legal || we) ? 32'h0 : ((srd >> (8 * off)) & mask);
    eaddr = addr & 32'hFFFF_FFFC;

    check("cmd_ready_idle", 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_size_i  = size;
    cmd_addr_i  = addr;
    cmd_wdata_i = wd;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'($urandom);
    cmd_size_i  = 2'($urandom);
    cmd_addr_i  = $urandom;
    cmd_wdata_i = $urandom;

    if (legal) begin
      for (int i = 0; i <= gd; i++) begin
        check("req",         32'(req_if.req),  32'd1);
        check("req_we",      32'(req_if.we),   32'(we));
        check("req_be",      32'(req_if.be),   32'(ebe));
        check("req_addr",    req_if.addr,      eaddr);
        check("req_wdata",   req_if.wdata,     ewd);
        check("cmd_ready_busy", 32'(cmd_ready_o), 32'd0);
        check("rsp_valid_early", 32'(rsp_valid_o), 32'd0);
        req_if.gnt = (i == gd);
        @(negedge clk_i);
      end
      req_if.gnt = 1'b0;
      for (int i = 0; i < rd; i++) begin
        check("wait_req",  32'(req_if.req),  32'd0);
        check("wait_busy", 32'(busy_o),      32'd1);
        check("wait_rsp",  32'(rsp_valid_o), 32'd0);
        @(negedge clk_i);
      end
      check("wait_req", 32'(req_if.req), 32'd0);
      rsp_if.rvalid = 1'b1;
      rsp_if.rdata  = srd;
      @(negedge clk_i);
      rsp_if.rvalid = 1'b0;
      rsp_if.rdata  = $urandom;
    end

    check("rsp_valid", 32'(rsp_valid_o), 32'd1);
    check("rsp_err",   32'(rsp_err_o),   32'(!legal));
    check("rsp_rdata", rsp_rdata_o,      erd);
    check("rsp_noreq", 32'(req_if.req),  32'd0);
    for (int i = 0; i < pd; i++) begin
      rsp_ready_i = 1'b0;
      @(negedge clk_i);
      check("rsp_hold_valid", 32'(rsp_valid_o), 32'd1);
      check("rsp_hold_rdata", rsp_rdata_o,      erd);
      check("rsp_hold_err",   32'(rsp_err_o),   32'(!legal));
      check("rsp_hold_cmdrdy", 32'(cmd_ready_o), 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    check("rsp_done_valid", 32'(rsp_valid_o), 32'd0);
    check("rsp_done_busy",  32'(busy_o),      32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    check("rst_busy",      32'(busy_o),      32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_rsp_rdata", rsp_rdata_o,      32'd0);
    check("rst_rsp_err",   32'(rsp_err_o),   32'd0);
    check("rst_req",       32'(req_if.req),  32'd0);
    check("rst_we",        32'(req_if.we),   32'd0);
    check("rst_be",        32'(req_if.be),   32'd0);
    check("rst_addr",      req_if.addr,      32'd0);
    check("rst_wdata",     req_if.wdata,     32'd0);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_ni        = 1'b1;
    cmd_valid_i   = 1'b0;
    cmd_we_i      = 1'b0;
    cmd_size_i    = 2'd0;
    cmd_addr_i    = 32'h0;
    cmd_wdata_i   = 32'h0;
    rsp_ready_i   = 1'b0;
    req_if.gnt    = 1'b0;
    rsp_if.rvalid = 1'b0;
    rsp_if.rdata  = 32'h0;

    #2 rst_ni = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Directed: word write, byte write, half read, misaligned word, reserved size
    run_cmd(1'b1, 2'd2, 32'h0000_0000, 32'h0000_0001, 32'hDEAD_BEEF, 0, 0, 0);
    run_cmd(1'b1, 2'd0, 32'h0000_0006, 32'h0000_00AB, 32'h0,         0, 0, 0);
    run_cmd(1'b0, 2'd1, 32'h0000_0002, 32'h0,         32'h1234_5678, 0, 0, 0);
    run_cmd(1'b0, 2'd2, 32'h0000_0001, 32'h0,         32'h1111_1111, 0, 0, 0);
    run_cmd(1'b1, 2'd3, 32'h0000_0008, 32'hFFFF_FFFF, 32'h0,         0, 0, 1);
    // Slow grant, delayed rvalid, stalled response consumer
    run_cmd(1'b0, 2'd0, 32'h0000_0013, 32'h0,         32'hA1B2_C3D4, 3, 1, 4);

    // Reset while waiting for rvalid abandons the transaction
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b0;
    cmd_size_i  = 2'd2;
    cmd_addr_i  = 32'h0000_0040;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    req_if.gnt  = 1'b1;
    @(negedge clk_i);
    req_if.gnt  = 1'b0;
    check("pre_rst_busy", 32'(busy_o), 32'd1);
    rst_ni = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_cmd(1'b0, 2'd2, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 1, 0, 0);

    // Randomized commands, mostly legal, arbitrary sub-word offsets
    for (int n = 0; n < 60; n++) begin
      logic [1:0] sz;
      sz = (($urandom % 8) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      run_cmd(1'($urandom), sz, {16'h0, 16'($urandom)}, $urandom, $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
